// File: rtl/fwd_chain_pkg.sv
// fwd_chain_pkg
// Shared constants and helpers for the forwarding chain.
//   MAX_NCH   - largest supported channel count
//   MAX_DEPTH - largest supported number of register slices per hop
//   ERR_CH_W  - width of the err_ch channel index
//   slices()  - total register slices in one channel (three hops)
package fwd_chain_pkg;

  localparam int MAX_NCH   = 8;
  localparam int MAX_DEPTH = 4;
  localparam int ERR_CH_W  = 3;

  function automatic int slices(input int depth);
    return 3 * depth;
  endfunction

endpackage

// File: rtl/fwd_slice.sv
// fwd_slice
// One valid/ready register slice holding a single word.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   in_data    - upstream data
//   in_valid   - upstream valid
//   out_ready  - downstream ready
//   out_data   - registered data presented downstream
//   out_valid  - slice is full
// The upstream ready of this slice is (!full || out_ready). The parent
// computes that term itself as a look-ahead across the whole chain, so
// the slice does not export it.
module fwd_slice
  import fwd_chain_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             load;

  assign load = !full_q || out_ready;

  // When the slice may load, its fullness simply follows the upstream
  // valid; data only changes on a real transfer so it stays stable
  // while held and keeps its last value once drained.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load) begin
      full_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = full_q;

endmodule

// File: rtl/fwd_chain.sv
// fwd_chain
// NCH independent elastic pipelines, each three hops of DEPTH slices,
// with a per-channel scoreboard that checks words exit unmodified and
// in order.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   x, x_valid/x_ready - per-channel source (channel c at c*WIDTH)
//   y, y_valid/y_ready - per-channel sink
//   foo, bar          - data registers at the end of hop 1 and hop 2
//   err               - sticky scoreboard error
//   err_ch            - channel of the first error (lowest index on ties)
module fwd_chain
  import fwd_chain_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 2,
  parameter int DEPTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] x,
  input  logic [NCH-1:0]       x_valid,
  output logic [NCH-1:0]       x_ready,
  output logic [NCH*WIDTH-1:0] y,
  output logic [NCH-1:0]       y_valid,
  input  logic [NCH-1:0]       y_ready,
  output logic [NCH*WIDTH-1:0] foo,
  output logic [NCH*WIDTH-1:0] bar,
  output logic                 err,
  output logic [ERR_CH_W-1:0]  err_ch
);

  localparam int S  = slices(DEPTH);
  localparam int PW = (S > 1) ? $clog2(S) : 1;
  localparam int CW = $clog2(S + 1);

  logic [WIDTH-1:0]     tail_data [NCH];
  logic [WIDTH-1:0]     hop1_data [NCH];
  logic [WIDTH-1:0]     hop2_data [NCH];
  logic [NCH*WIDTH-1:0] y_raw, foo_raw, bar_raw;
  logic [NCH-1:0]       x_ready_raw, y_valid_raw, ch_err;

  logic                err_q, err_d;
  logic [ERR_CH_W-1:0] err_ch_q, err_ch_d, first_ch;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [WIDTH-1:0] dat [S+1];
    logic [S:0]       vld;
    logic [S:0]       rdy;

    assign dat[0] = x[c*WIDTH +: WIDTH];
    assign vld[0] = x_valid[c];
    assign rdy[S] = y_ready[c];

    // Ready into slice k is true when the sink is ready or any slice from
    // k onward has a hole. Built from the full flags directly so there is
    // no combinational ripple through the chain.
    for (genvar k = 0; k < S; k++) begin : g_rdy
      assign rdy[k] = y_ready[c] | ~(&vld[S:k+1]);
    end

    for (genvar s = 0; s < S; s++) begin : g_sl
      fwd_slice #(.WIDTH(WIDTH)) u_slice (
        .clk      (clk),
        .rst      (rst),
        .in_data  (dat[s]),
        .in_valid (vld[s]),
        .out_ready(rdy[s+1]),
        .out_data (dat[s+1]),
        .out_valid(vld[s+1])
      );
    end

    assign x_ready_raw[c] = rdy[0];
    assign y_valid_raw[c] = vld[S];
    assign tail_data[c]   = dat[S];
    assign hop1_data[c]   = dat[DEPTH];
    assign hop2_data[c]   = dat[2*DEPTH];

    logic [WIDTH-1:0] sb_mem_q [S];
    logic [WIDTH-1:0] sb_mem_d [S];
    logic [PW-1:0]    sb_wr_q, sb_wr_d, sb_rd_q, sb_rd_d;
    logic [CW-1:0]    sb_cnt_q, sb_cnt_d;
    logic             push, pop, push_ok, pop_ok, sb_empty, sb_full;

    assign push     = x_valid[c] & x_ready[c];
    assign pop      = y_valid[c] & y_ready[c];
    assign sb_empty = (sb_cnt_q == '0);
    assign sb_full  = (sb_cnt_q == CW'(S));
    assign push_ok  = push & (~sb_full | pop);
    assign pop_ok   = pop & ~sb_empty;

    // An exit with nothing recorded, an exit that differs from the oldest
    // recorded word, or an entry with no room are all consistency errors.
    assign ch_err[c] = (pop & (sb_empty | (sb_mem_q[sb_rd_q] != y_raw[c*WIDTH +: WIDTH])))
                     | (push & sb_full & ~pop);

    // Circular scoreboard; pointers wrap at S, which need not be a power
    // of two.
    always_comb begin
      sb_mem_d = sb_mem_q;
      sb_wr_d  = sb_wr_q;
      sb_rd_d  = sb_rd_q;
      sb_cnt_d = sb_cnt_q;
      if (push_ok) begin
        sb_mem_d[sb_wr_q] = x[c*WIDTH +: WIDTH];
        sb_wr_d = (sb_wr_q == PW'(S - 1)) ? '0 : sb_wr_q + 1'b1;
      end
      if (pop_ok) begin
        sb_rd_d = (sb_rd_q == PW'(S - 1)) ? '0 : sb_rd_q + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        sb_cnt_d = sb_cnt_q + 1'b1;
      end else if (!push_ok && pop_ok) begin
        sb_cnt_d = sb_cnt_q - 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sb_mem_q <= '{default: '0};
        sb_wr_q  <= '0;
        sb_rd_q  <= '0;
        sb_cnt_q <= '0;
      end else begin
        sb_mem_q <= sb_mem_d;
        sb_wr_q  <= sb_wr_d;
        sb_rd_q  <= sb_rd_d;
        sb_cnt_q <= sb_cnt_d;
      end
    end
  end

  always_comb begin
    y_raw   = '0;
    foo_raw = '0;
    bar_raw = '0;
    for (int i = 0; i < NCH; i++) begin
      y_raw[i*WIDTH +: WIDTH]   = tail_data[i];
      foo_raw[i*WIDTH +: WIDTH] = hop1_data[i];
      bar_raw[i*WIDTH +: WIDTH] = hop2_data[i];
    end
  end

  // Scanning downward leaves the lowest failing channel in first_ch.
  // err_ch only latches on the cycle err first rises.
  always_comb begin
    first_ch = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ch_err[i]) begin
        first_ch = ERR_CH_W'(i);
      end
    end
    err_d    = err_q | (|ch_err);
    err_ch_d = err_ch_q;
    if (!err_q && (|ch_err)) begin
      err_ch_d = first_ch;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q    <= 1'b0;
      err_ch_q <= '0;
    end else begin
      err_q    <= err_d;
      err_ch_q <= err_ch_d;
    end
  end

  // Outputs are forced quiet while reset is held, including the first
  // reset cycle before the registers have cleared.
  assign x_ready = x_ready_raw & {NCH{~rst}};
  assign y_valid = y_valid_raw & {NCH{~rst}};
  assign y       = rst ? '0 : y_raw;
  assign foo     = rst ? '0 : foo_raw;
  assign bar     = rst ? '0 : bar_raw;
  assign err     = err_q & ~rst;
  assign err_ch  = rst ? '0 : err_ch_q;

endmodule

// File: tb/tb_fwd_chain.sv
module tb_fwd_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut_a: WIDTH=8, NCH=3, DEPTH=1
  logic        rst_a;
  logic [23:0] x_a, y_a, foo_a, bar_a;
  logic [2:0]  x_valid_a, x_ready_a, y_valid_a, y_ready_a, err_ch_a;
  logic        err_a;

  // dut_b: WIDTH=8, NCH=2, DEPTH=2
  logic        rst_b;
  logic [15:0] x_b, y_b, foo_b, bar_b;
  logic [1:0]  x_valid_b, x_ready_b, y_valid_b, y_ready_b;
  logic [2:0]  err_ch_b;
  logic        err_b;

  int test_count = 0;
  int fail_count = 0;

  fwd_chain #(.WIDTH(8), .NCH(3), .DEPTH(1)) dut_a (
    .clk(clk), .rst(rst_a), .x(x_a), .x_valid(x_valid_a), .x_ready(x_ready_a),
    .y(y_a), .y_valid(y_valid_a), .y_ready(y_ready_a), .foo(foo_a), .bar(bar_a),
    .err(err_a), .err_ch(err_ch_a)
  );

  fwd_chain #(.WIDTH(8), .NCH(2), .DEPTH(2)) dut_b (
    .clk(clk), .rst(rst_b), .x(x_b), .x_valid(x_valid_b), .x_ready(x_ready_b),
    .y(y_b), .y_valid(y_valid_b), .y_ready(y_ready_b), .foo(foo_b), .bar(bar_b),
    .err(err_b), .err_ch(err_ch_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    rst_a     = 1'b1;
    x_valid_a = '0;
    step();
    step();
    rst_a = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    test_count++;
    if (x_ready_a !== 3'b000) begin fail_count++; $display("[TB] FAIL rst_x_ready: got %b want 000", x_ready_a); end
    test_count++;
    if (y_valid_a !== 3'b000) begin fail_count++; $display("[TB] FAIL rst_y_valid: got %b want 000", y_valid_a); end
    test_count++;
    if (err_a !== 1'b0 || err_ch_a !== 3'd0) begin fail_count++; $display("[TB] FAIL rst_err: got %b/%0d want 0/0", err_a, err_ch_a); end
    test_count++;
    if (y_a !== 24'h0 || foo_a !== 24'h0 || bar_a !== 24'h0) begin
      fail_count++; $display("[TB] FAIL rst_data: got y=%h foo=%h bar=%h want 0", y_a, foo_a, bar_a);
    end
    test_count++;
    if (x_ready_b !== 2'b00) begin fail_count++; $display("[TB] FAIL rst_x_ready_b: got %b want 00", x_ready_b); end
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    test_count++;
    if (x_ready_a !== 3'b111) begin fail_count++; $display("[TB] FAIL post_rst_x_ready: got %b want 111", x_ready_a); end
    test_count++;
    if (x_ready_b !== 2'b11) begin fail_count++; $display("[TB] FAIL post_rst_x_ready_b: got %b want 11", x_ready_b); end
  endtask

  task automatic test_single();
    y_ready_a = 3'b111;
    x_a       = 24'h00005A;
    x_valid_a = 3'b001;
    #1;
    test_count++;
    if (x_ready_a[0] !== 1'b1) begin fail_count++; $display("[TB] FAIL single_x_ready: got %b want 1", x_ready_a[0]); end
    step();
    x_valid_a = 3'b000;
    test_count++;
    if (foo_a[7:0] !== 8'h5A) begin fail_count++; $display("[TB] FAIL single_foo: got %h want 5a", foo_a[7:0]); end
    test_count++;
    if (y_valid_a !== 3'b000) begin fail_count++; $display("[TB] FAIL single_early_y: got %b want 000", y_valid_a); end
    step();
    test_count++;
    if (bar_a[7:0] !== 8'h5A) begin fail_count++; $display("[TB] FAIL single_bar: got %h want 5a", bar_a[7:0]); end
    step();
    test_count++;
    if (y_valid_a !== 3'b001 || y_a[7:0] !== 8'h5A) begin
      fail_count++; $display("[TB] FAIL single_y: got valid=%b y=%h want 001/5a", y_valid_a, y_a[7:0]);
    end
    test_count++;
    if (err_a !== 1'b0) begin fail_count++; $display("[TB] FAIL single_err: got %b want 0", err_a); end
    step();
    test_count++;
    if (y_valid_a !== 3'b000) begin fail_count++; $display("[TB] FAIL single_drained: got %b want 000", y_valid_a); end
  endtask

  task automatic test_stream();
    logic [15:0] exp_y;
    y_ready_b = 2'b11;
    for (int t = 0; t < 24; t++) begin
      if (t < 16) begin
        x_b       = {8'(t + 128), 8'(t)};
        x_valid_b = 2'b11;
      end else begin
        x_valid_b = 2'b00;
      end
      #1;
      if (t < 16) begin
        test_count++;
        if (x_ready_b !== 2'b11) begin fail_count++; $display("[TB] FAIL stream_x_ready t=%0d: got %b want 11", t, x_ready_b); end
      end
      if (t >= 6 && t < 22) begin
        exp_y = {8'(t - 6 + 128), 8'(t - 6)};
        test_count++;
        if (y_valid_b !== 2'b11 || y_b !== exp_y) begin
          fail_count++; $display("[TB] FAIL stream_y t=%0d: got %b/%h want 11/%h", t, y_valid_b, y_b, exp_y);
        end
      end else begin
        test_count++;
        if (y_valid_b !== 2'b00) begin fail_count++; $display("[TB] FAIL stream_idle t=%0d: got %b want 00", t, y_valid_b); end
      end
      step();
    end
    test_count++;
    if (err_b !== 1'b0) begin fail_count++; $display("[TB] FAIL stream_err: got %b want 0", err_b); end
  endtask

  task automatic test_backpressure();
    logic [7:0] words [3];
    words     = '{8'h11, 8'h22, 8'h33};
    y_ready_a = 3'b110;
    for (int i = 0; i < 3; i++) begin
      x_a       = {16'h0, words[i]};
      x_valid_a = 3'b001;
      #1;
      test_count++;
      if (x_ready_a[0] !== 1'b1) begin fail_count++; $display("[TB] FAIL bp_accept%0d: got %b want 1", i, x_ready_a[0]); end
      step();
    end
    x_a = 24'h000044;
    #1;
    for (int i = 0; i < 4; i++) begin
      test_count++;
      if (x_ready_a[0] !== 1'b0 || y_valid_a[0] !== 1'b1 || y_a[7:0] !== 8'h11) begin
        fail_count++;
        $display("[TB] FAIL bp_hold%0d: got rdy=%b vld=%b y=%h want 0/1/11", i, x_ready_a[0], y_valid_a[0], y_a[7:0]);
      end
      step();
    end
    x_valid_a = 3'b000;
    y_ready_a = 3'b111;
    #1;
    for (int i = 0; i < 3; i++) begin
      test_count++;
      if (y_valid_a[0] !== 1'b1 || y_a[7:0] !== words[i]) begin
        fail_count++; $display("[TB] FAIL bp_drain%0d: got %b/%h want 1/%h", i, y_valid_a[0], y_a[7:0], words[i]);
      end
      step();
    end
    test_count++;
    if (y_valid_a !== 3'b000 || err_a !== 1'b0) begin
      fail_count++; $display("[TB] FAIL bp_end: got vld=%b err=%b want 000/0", y_valid_a, err_a);
    end
  endtask

  task automatic test_corrupt_ch1();
    reset_a();
    y_ready_a = 3'b111;
    x_a       = 24'h007700;
    x_valid_a = 3'b010;
    #1;
    step();
    x_valid_a = 3'b000;
    step();
    step();
    test_count++;
    if (y_valid_a !== 3'b010 || y_a[15:8] !== 8'h77) begin
      fail_count++; $display("[TB] FAIL c1_arrive: got %b/%h want 010/77", y_valid_a, y_a[15:8]);
    end
    force dut_a.y_raw = 24'h00EE00;
    #1;
    test_count++;
    if (err_a !== 1'b0) begin fail_count++; $display("[TB] FAIL c1_err_early: got %b want 0", err_a); end
    step();
    release dut_a.y_raw;
    test_count++;
    if (err_a !== 1'b1 || err_ch_a !== 3'd1) begin
      fail_count++; $display("[TB] FAIL c1_err: got %b/%0d want 1/1", err_a, err_ch_a);
    end
    x_a       = 24'h550000;
    x_valid_a = 3'b100;
    #1;
    step();
    x_valid_a = 3'b000;
    step();
    step();
    test_count++;
    if (y_valid_a !== 3'b100) begin fail_count++; $display("[TB] FAIL c1_ch2_arrive: got %b want 100", y_valid_a); end
    force dut_a.y_raw = 24'hAA0000;
    #1;
    step();
    release dut_a.y_raw;
    step();
    step();
    test_count++;
    if (err_a !== 1'b1 || err_ch_a !== 3'd1) begin
      fail_count++; $display("[TB] FAIL c1_sticky: got %b/%0d want 1/1", err_a, err_ch_a);
    end
  endtask

  task automatic test_corrupt_multi();
    reset_a();
    y_ready_a = 3'b111;
    x_a       = 24'h300010;
    x_valid_a = 3'b101;
    #1;
    step();
    x_valid_a = 3'b000;
    step();
    step();
    test_count++;
    if (y_valid_a !== 3'b101) begin fail_count++; $display("[TB] FAIL multi_arrive: got %b want 101", y_valid_a); end
    force dut_a.y_raw = 24'hF000F1;
    #1;
    step();
    release dut_a.y_raw;
    test_count++;
    if (err_a !== 1'b1 || err_ch_a !== 3'd0) begin
      fail_count++; $display("[TB] FAIL multi_err_ch: got %b/%0d want 1/0", err_a, err_ch_a);
    end
  endtask

  task automatic test_reset_mid();
    reset_a();
    y_ready_a = 3'b111;
    x_a       = 24'h0000A1;
    x_valid_a = 3'b001;
    #1;
    step();
    x_a = 24'h0000A2;
    #1;
    step();
    x_valid_a = 3'b000;
    rst_a     = 1'b1;
    #1;
    test_count++;
    if (x_ready_a !== 3'b000 || y_valid_a !== 3'b000 || foo_a !== 24'h0) begin
      fail_count++; $display("[TB] FAIL mid_in_rst: got rdy=%b vld=%b foo=%h want 000/000/0", x_ready_a, y_valid_a, foo_a);
    end
    step();
    rst_a = 1'b0;
    #1;
    test_count++;
    if (x_ready_a !== 3'b111) begin fail_count++; $display("[TB] FAIL mid_x_ready: got %b want 111", x_ready_a); end
    for (int i = 0; i < 3; i++) begin
      test_count++;
      if (y_valid_a !== 3'b000 || err_a !== 1'b0) begin
        fail_count++; $display("[TB] FAIL mid_quiet%0d: got vld=%b err=%b want 000/0", i, y_valid_a, err_a);
      end
      step();
    end
  endtask

  initial begin
    rst_a = 1'b1; x_a = '0; x_valid_a = '0; y_ready_a = '0;
    rst_b = 1'b1; x_b = '0; x_valid_b = '0; y_ready_b = '0;
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_corrupt_ch1();
    test_corrupt_multi();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
